multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Sequencing controller for the multi-cycle RV32I core.
- Shares one memory port between instruction fetch and load/store.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the same datapath select signals as the single-cycle decoder.
- Sits between the IR/PC/ALUOut/MDR registers of the datapath and the unified memory.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready in FETCH or MEM before bus error.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable, sampled only at the instruction boundary (FETCH, no request outstanding)
- inst  in  32  current IR contents from the datapath
- BrEq  in  1  branch comparator equal
- BrLt  in  1  branch comparator less-than
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write (store), 0 = read
- addr_sel  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pcsel  out  1  PC source: 0 = PC+4, 1 = ALU result (EXEC) / ALUOut (WB)
- immSel  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- RegWEn  out  1  register file write
- BrUn  out  1  unsigned compare
- ASel  out  1  0 = rs1, 1 = PC
- BSel  out  1  0 = rs2, 1 = imm
- ALUSel  out  3  0 = add, 1 = sub, 4 = pass B
- WBSel  out  2  0 = mem, 1 = ALU, 2 = PC+4
- state_o  out  3  current state
- instret  out  CNT_W  retired instruction count
- illegal_inst  out  1  sticky: illegal opcode/funct seen
- bus_err  out  1  sticky: memory timeout

Behaviour:
- Reset (sync, any state, including mid-request): state = FETCH; all outputs 0; instret = 0; sticky flags cleared; wait counter cleared. mem_req drops in the cycle after rst is sampled.
- Unlisted outputs are 0 in every state. No latches.
- FETCH:
  - If en = 1: mem_req = 1, addr_sel = 0, mem_we = 0.
  - Once asserted, mem_req is held regardless of en until mem_ready.
  - On mem_ready: ir_we = 1, go to DECODE.
- DECODE:
  - Classify inst.
  - Illegal encoding goes to HALT and sets illegal_inst.
  - Legal opcodes: 0110011 (add/sub only; funct7 0000000 / 0100000), 0010011 (addi), 0000011 (lw), 0100011 (sw), 1100011 (funct3 000/001/100/101/110/111), 1101111, 1100111, 0110111 (LUI), 0010111 (AUIPC).
- EXEC, ALU inputs by class:
  - R: ASel = 0, BSel = 0, ALUSel per funct7.
  - addi/lw/sw/jalr: ASel = 0, BSel = 1, immSel = I/I/S/I.
  - Branch/JAL/AUIPC: ASel = 1, BSel = 1, immSel = B/J/U.
  - LUI: BSel = 1, immSel = U, ALUSel = 4.
- EXEC, branch resolution:
  - BrUn = funct3[1].
  - taken = BrEq (000), ~BrEq (001), BrLt (100/110), ~BrLt (101/111).
  - pc_we = 1, pcsel = taken. Next state FETCH.
- EXEC, next state: lw/sw go to MEM; all other non-branch classes go to WB.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = 1 for sw.
  - On mem_ready: sw sets pc_we = 1, pcsel = 0 and goes to FETCH; lw goes to WB.
- WB:
  - RegWEn = 1, pc_we = 1.
  - WBSel = 0 (lw), 2 (JAL/JALR), 1 otherwise.
  - pcsel = 1 for JAL/JALR, else 0.
  - Next state FETCH.
- Retirement: instret += 1 in the cycle pc_we = 1. Wraps at 2^CNT_W.
- Timeout:
  - Wait counter counts cycles with mem_req = 1 and mem_ready = 0.
  - Reaching TIMEOUT goes to HALT and sets bus_err.
  - Counter clears on mem_ready or on leaving the state.
- HALT: all strobes 0. Exit only via rst.
- Latency with mem_ready in the same cycle as mem_req: branch 3 cycles; sw, R, I, LUI, AUIPC, JAL, JALR 4 cycles; lw 5 cycles.
- rs1/rs2/rd field extraction stays in the datapath.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants;
  - state encoding (FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5);
  - immSel, WBSel and ALUSel encodings;
  - instruction-class encoding.
- One combinational sub-module, ctrl_class_decode: inst to {class, legal}.
- FSM, counters and output logic live in multicycle_ctrl_fsm.

Test Plan:
- rst held 2 cycles, then en = 1, mem_ready tied 1, inst = addi x1,x0,5 (0x00500093) -> states 0,1,2,4. WB shows RegWEn = 1, WBSel = 1, pc_we = 1, pcsel = 0. instret = 1 after 4 cycles.
- lw 0x0000A103, with mem_ready delayed 3 cycles in MEM -> mem_req and addr_sel = 1 held 4 cycles. WB has WBSel = 0. Total 8 cycles. instret increments once.
- bne (0x00209463) with BrEq = 0 -> EXEC has pc_we = 1, pcsel = 1, immSel = 2, BrUn = 0, then FETCH. Repeat bltu with BrLt = 0 -> pcsel = 0, BrUn = 1.
- mem_ready never asserted with TIMEOUT = 16 -> HALT after 16 wait cycles, bus_err = 1, mem_req = 0. Only rst returns to FETCH with bus_err = 0.
- inst = 0xFFFFFFFF -> DECODE goes to HALT, illegal_inst = 1, no pc_we/RegWEn pulse. inst = 0x00000017 (AUIPC) decodes legal with ASel = 1, immSel = 4.
- rst asserted in MEM of sw with mem_req high -> next cycle state = 0, mem_req = 0, mem_we = 0. With en = 0 no new fetch is issued. Drop en mid-FETCH-wait -> mem_req is held until mem_ready.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select codes and the instruction classes produced by the decoder.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_PASS_B = 3'd4
  } alu_sel_e;

  typedef enum logic [3:0] {
    CL_R,
    CL_ADDI,
    CL_LW,
    CL_SW,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC
  } iclass_e;

endpackage

// File: rtl/ctrl_class_decode.sv
// Combinational classifier: maps opcode/funct fields of the IR onto an
// instruction class and flags encodings outside the supported subset.
module ctrl_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_e    iclass,
  output logic       legal
);

  always_comb begin
    iclass = CL_R;
    legal  = 1'b0;
    case (opcode)
      OP_R: begin
        iclass = CL_R;
        legal  = (funct3 == 3'b000) && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      OP_IMM: begin
        iclass = CL_ADDI;
        legal  = (funct3 == 3'b000);
      end
      OP_LOAD: begin
        iclass = CL_LW;
        legal  = (funct3 == 3'b010);
      end
      OP_STORE: begin
        iclass = CL_SW;
        legal  = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        iclass = CL_BRANCH;
        legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL: begin
        iclass = CL_JAL;
        legal  = 1'b1;
      end
      OP_JALR: begin
        iclass = CL_JALR;
        legal  = (funct3 == 3'b000);
      end
      OP_LUI: begin
        iclass = CL_LUI;
        legal  = 1'b1;
      end
      OP_AUIPC: begin
        iclass = CL_AUIPC;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: walks each instruction through FETCH/DECODE/
// EXEC/MEM/WB over one shared memory port and counts retired instructions.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      inst,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pcsel,
  output logic [2:0]       immSel,
  output logic             RegWEn,
  output logic             BrUn,
  output logic             ASel,
  output logic             BSel,
  output logic [2:0]       ALUSel,
  output logic [1:0]       WBSel,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_inst,
  output logic             bus_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  iclass_e iclass;
  logic    legal;
  logic    br_taken;
  logic    timed_out;

  // rs1/rs2/rd and immediate bits are consumed by the datapath, not here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[29:15], inst[11:7]};

  ctrl_class_decode u_class_decode (
    .opcode (inst[6:0]),
    .funct3 (inst[14:12]),
    .funct7 (inst[31:25]),
    .iclass (iclass),
    .legal  (legal)
  );

  // funct3[2] picks the less-than compare, funct3[0] inverts the condition.
  assign br_taken  = (inst[14] ? BrLt : BrEq) ^ inst[12];
  assign timed_out = (wait_q == WAIT_LAST);

  always_comb begin
    // NOTE: every output and next-state variable gets a default first so no
    // path through the case below can leave one unassigned (no latches).
    state_d   = state_q;
    req_d     = 1'b0;
    wait_d    = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pcsel     = 1'b0;
    immSel    = IMM_I;
    RegWEn    = 1'b0;
    BrUn      = 1'b0;
    ASel      = 1'b0;
    BSel      = 1'b0;
    ALUSel    = ALU_ADD;
    WBSel     = WB_MEM;

    case (state_q)
      S_FETCH: begin
        mem_req = en | req_q;
        if (mem_req) begin
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (timed_out) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
          end else begin
            req_d  = 1'b1;
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (iclass)
          CL_R: ALUSel = inst[30] ? ALU_SUB : ALU_ADD;
          CL_ADDI, CL_JALR: BSel = 1'b1;
          CL_LW: begin
            BSel    = 1'b1;
            state_d = S_MEM;
          end
          CL_SW: begin
            BSel    = 1'b1;
            immSel  = IMM_S;
            state_d = S_MEM;
          end
          CL_BRANCH: begin
            ASel    = 1'b1;
            BSel    = 1'b1;
            immSel  = IMM_B;
            BrUn    = inst[13];
            pc_we   = 1'b1;
            pcsel   = br_taken;
            state_d = S_FETCH;
          end
          CL_JAL: begin
            ASel   = 1'b1;
            BSel   = 1'b1;
            immSel = IMM_J;
          end
          CL_AUIPC: begin
            ASel   = 1'b1;
            BSel   = 1'b1;
            immSel = IMM_U;
          end
          CL_LUI: begin
            BSel   = 1'b1;
            immSel = IMM_U;
            ALUSel = ALU_PASS_B;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (iclass == CL_SW);
        if (mem_ready) begin
          if (iclass == CL_SW) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        RegWEn  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (iclass == CL_LW) begin
          WBSel = WB_MEM;
        end else if (iclass == CL_JAL || iclass == CL_JALR) begin
          WBSel = WB_PC4;
          pcsel = 1'b1;
        end else begin
          WBSel = WB_ALU;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    instret_d = instret_q + CNT_W'(pc_we);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // computed above from the same pre-edge state.
    if (rst) begin
      state_q   <= S_FETCH;
      req_q     <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state_o      = state_q;
  assign instret      = instret_q;
  assign illegal_inst = illegal_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: a directed vector table, a randomized run
// against an opcode-level reference model, and hand-written corner sequences.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, en, BrEq, BrLt, mem_ready;
  logic [31:0] inst;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pcsel, RegWEn, BrUn, ASel, BSel;
  logic [2:0]  immSel, ALUSel, state_o;
  logic [1:0]  WBSel;
  logic [31:0] instret;
  logic        illegal_inst, bus_err;

  int errors = 0;
  int checks = 0;
  int exp_instret;

  multicycle_ctrl_fsm #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .inst(inst), .BrEq(BrEq), .BrLt(BrLt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pcsel(pcsel), .immSel(immSel), .RegWEn(RegWEn),
    .BrUn(BrUn), .ASel(ASel), .BSel(BSel), .ALUSel(ALUSel), .WBSel(WBSel),
    .state_o(state_o), .instret(instret), .illegal_inst(illegal_inst), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_instret = 0;
  endtask

  typedef struct {
    logic [31:0] trace;
    int          cycles;
    int          pcw;
    int          memc;
    logic        asel, bsel, brun, pcsel, regwen, memwe;
    logic [2:0]  imm, alu, end_state;
    logic [1:0]  wbsel;
    bit          done;
  } obs_t;

  // Runs one instruction from FETCH; memory answers after fw/mw wait cycles.
  task automatic run_instr(input logic [31:0] i, input logic beq, input logic blt,
                           input int fw, input int mw, output obs_t o);
    int fcnt, mcnt;
    o.trace = '0; o.cycles = 0; o.pcw = 0; o.memc = 0;
    o.asel = 0; o.bsel = 0; o.brun = 0; o.pcsel = 0; o.regwen = 0; o.memwe = 0;
    o.imm = '0; o.alu = '0; o.end_state = '0; o.wbsel = '0; o.done = 0;
    inst = i; BrEq = beq; BrLt = blt; en = 1'b1;
    fcnt = 0; mcnt = 0;
    for (int n = 0; n < 80 && !o.done; n++) begin
      #1;
      if (mem_req && state_o == 3'd0) begin
        mem_ready = (fcnt == fw); fcnt++;
      end else if (mem_req && state_o == 3'd3) begin
        mem_ready = (mcnt == mw); mcnt++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      o.trace = {o.trace[27:0], 1'b0, state_o};
      o.cycles++;
      o.end_state = state_o;
      if (state_o == 3'd2) begin
        o.asel = ASel; o.bsel = BSel; o.imm = immSel; o.alu = ALUSel; o.brun = BrUn;
      end
      if (state_o == 3'd3 && addr_sel && mem_req) begin
        o.memc++; o.memwe = o.memwe | mem_we;
      end
      if (state_o == 3'd4) begin
        o.regwen = RegWEn; o.wbsel = WBSel;
      end
      if (pc_we) begin
        o.pcw++; o.pcsel = pcsel; o.done = 1;
      end
      if (state_o == 3'd5) o.done = 1;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        beq, blt;
    int          fw, mw;
    logic [31:0] trace;
    int          cycles, memc;
    logic        asel, bsel;
    logic [2:0]  imm, alu;
    logic        brun, pcsel;
    logic [1:0]  wbsel;
    logic        regwen, memwe;
  } vec_t;

  typedef struct {
    logic        asel, bsel, brun, pcsel, regwen, memwe;
    logic [2:0]  imm, alu;
    logic [1:0]  wbsel;
    int          cycles, memc;
  } exp_t;

  // Reference: what each opcode should make the controller do, from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input logic beq, input logic blt,
                                 input int fw, input int mw);
    exp_t e;
    logic [2:0] f3;
    bit uses_mem, writes_reg;
    f3 = i[14:12];
    e.asel = 0; e.bsel = 1; e.brun = 0; e.pcsel = 0; e.memwe = 0;
    e.imm = 3'd0; e.alu = 3'd0; e.wbsel = 2'd1;
    uses_mem = 0; writes_reg = 1;
    case (i[6:0])
      7'h33: begin e.bsel = 0; e.alu = (i[31:25] == 7'h20) ? 3'd1 : 3'd0; end
      7'h13: ;
      7'h03: begin uses_mem = 1; e.wbsel = 2'd0; end
      7'h23: begin uses_mem = 1; writes_reg = 0; e.imm = 3'd1; e.memwe = 1; e.wbsel = 2'd0; end
      7'h63: begin
        e.asel = 1; e.imm = 3'd2; e.brun = f3[1]; writes_reg = 0; e.wbsel = 2'd0;
        case (f3)
          3'd0: e.pcsel = beq;
          3'd1: e.pcsel = !beq;
          3'd4, 3'd6: e.pcsel = blt;
          default: e.pcsel = !blt;
        endcase
      end
      7'h6F: begin e.asel = 1; e.imm = 3'd3; e.wbsel = 2'd2; e.pcsel = 1; end
      7'h67: begin e.wbsel = 2'd2; e.pcsel = 1; end
      7'h37: begin e.imm = 3'd4; e.alu = 3'd4; end
      default: begin e.asel = 1; e.imm = 3'd4; end
    endcase
    e.regwen = writes_reg;
    e.memc   = uses_mem ? 1 + mw : 0;
    e.cycles = 3 + fw + e.memc + (writes_reg ? 1 : 0);
    return e;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    logic [2:0]  bf [6];
    logic [6:0]  ops [9];
    bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 8)];
    case (r[6:0])
      7'h33: begin r[14:12] = 3'd0; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      7'h13, 7'h67: r[14:12] = 3'd0;
      7'h03, 7'h23: r[14:12] = 3'd2;
      7'h63: r[14:12] = bf[$urandom_range(0, 5)];
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit legal_opcode(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 ||
           op == 7'h6F || op == 7'h67 || op == 7'h37 || op == 7'h17;
  endfunction

  vec_t vecs [10];
  obs_t o;
  exp_t e;
  logic [31:0] bad [5];
  int wait_cycles;

  initial begin
    //               inst          beq blt fw mw trace        cyc memc as bs imm   alu  bu pcs wb    rw mw
    vecs[0] = '{32'h00500093, 0, 0, 0, 0, 32'h00000124, 4, 0, 0, 1, 3'd0, 3'd0, 0, 0, 2'd1, 1, 0};
    vecs[1] = '{32'h0000A103, 0, 0, 0, 3, 32'h01233334, 8, 4, 0, 1, 3'd0, 3'd0, 0, 0, 2'd0, 1, 0};
    vecs[2] = '{32'h00209463, 0, 0, 0, 0, 32'h00000012, 3, 0, 1, 1, 3'd2, 3'd0, 0, 1, 2'd0, 0, 0};
    vecs[3] = '{32'h0020E463, 1, 0, 0, 0, 32'h00000012, 3, 0, 1, 1, 3'd2, 3'd0, 1, 0, 2'd0, 0, 0};
    vecs[4] = '{32'h00000017, 0, 0, 0, 0, 32'h00000124, 4, 0, 1, 1, 3'd4, 3'd0, 0, 0, 2'd1, 1, 0};
    vecs[5] = '{32'h0020A023, 0, 0, 0, 1, 32'h00001233, 5, 2, 0, 1, 3'd1, 3'd0, 0, 0, 2'd0, 0, 1};
    vecs[6] = '{32'h123450B7, 0, 0, 0, 0, 32'h00000124, 4, 0, 0, 1, 3'd4, 3'd4, 0, 0, 2'd1, 1, 0};
    vecs[7] = '{32'h008000EF, 0, 0, 0, 0, 32'h00000124, 4, 0, 1, 1, 3'd3, 3'd0, 0, 1, 2'd2, 1, 0};
    vecs[8] = '{32'h000080E7, 0, 0, 0, 0, 32'h00000124, 4, 0, 0, 1, 3'd0, 3'd0, 0, 1, 2'd2, 1, 0};
    vecs[9] = '{32'h402081B3, 0, 1, 2, 0, 32'h00000124, 6, 0, 0, 0, 3'd0, 3'd1, 0, 0, 2'd1, 1, 0};

    inst = 32'h0; BrEq = 0; BrLt = 0;
    do_reset();
    check("reset.state", state_o, 0);
    check("reset.mem_req", mem_req, 0);
    check("reset.strobes", {pc_we, RegWEn, ir_we, mem_we, addr_sel}, 0);
    check("reset.instret", instret, 0);
    check("reset.flags", {illegal_inst, bus_err}, 0);

    for (int k = 0; k < 10; k++) begin
      run_instr(vecs[k].inst, vecs[k].beq, vecs[k].blt, vecs[k].fw, vecs[k].mw, o);
      exp_instret++;
      check($sformatf("v%0d.done", k), o.done, 1);
      check($sformatf("v%0d.trace", k), o.trace, vecs[k].trace);
      check($sformatf("v%0d.cycles", k), o.cycles, vecs[k].cycles);
      check($sformatf("v%0d.memc", k), o.memc, vecs[k].memc);
      check($sformatf("v%0d.alu_in", k), {o.asel, o.bsel, o.imm, o.alu}, {vecs[k].asel, vecs[k].bsel, vecs[k].imm, vecs[k].alu});
      check($sformatf("v%0d.brun", k), o.brun, vecs[k].brun);
      check($sformatf("v%0d.pcsel", k), o.pcsel, vecs[k].pcsel);
      check($sformatf("v%0d.wb", k), {o.regwen, o.wbsel}, {vecs[k].regwen, vecs[k].wbsel});
      check($sformatf("v%0d.memwe", k), o.memwe, vecs[k].memwe);
      check($sformatf("v%0d.pcw", k), o.pcw, 1);
      check($sformatf("v%0d.instret", k), instret, exp_instret);
    end

    // Fetch never answered: halt after TIMEOUT wait cycles, leave only via rst.
    do_reset();
    inst = 32'h00500093; en = 1'b1; mem_ready = 1'b0;
    wait_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (state_o == 3'd5) break;
      if (mem_req) wait_cycles++;
      tick();
    end
    check("timeout.wait_cycles", wait_cycles, 16);
    check("timeout.state", state_o, 5);
    check("timeout.bus_err", bus_err, 1);
    check("timeout.mem_req", mem_req, 0);
    tick(); tick(); tick();
    check("timeout.stay_halt", {state_o, mem_req, pc_we}, {3'd5, 1'b0, 1'b0});
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;
    #1;
    check("timeout.rst_state", state_o, 0);
    check("timeout.rst_bus_err", bus_err, 0);

    // Load whose data phase never completes.
    do_reset();
    run_instr(32'h0000A103, 0, 0, 0, 1000, o);
    check("memto.end_state", o.end_state, 5);
    check("memto.memc", o.memc, 16);
    check("memto.bus_err", bus_err, 1);
    check("memto.pcw", o.pcw, 0);

    // Illegal encodings halt from DECODE without retiring.
    bad[0] = 32'hFFFFFFFF;
    bad[1] = 32'h022081B3;
    bad[2] = 32'h00002013;
    for (int k = 3; k < 5; k++) begin
      bad[k] = $urandom;
      while (legal_opcode(bad[k][6:0])) bad[k] = $urandom;
    end
    for (int k = 0; k < 5; k++) begin
      do_reset();
      run_instr(bad[k], 0, 0, 0, 0, o);
      check($sformatf("ill%0d.trace", k), o.trace, 32'h015);
      check($sformatf("ill%0d.flag", k), {illegal_inst, bus_err}, 2'b10);
      check($sformatf("ill%0d.no_retire", k), {o.pcw != 0, o.regwen, instret != 0}, 0);
    end

    // Reset in the middle of a store's memory phase; en low keeps the bus idle.
    do_reset();
    inst = 32'h0020A023; en = 1'b1; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    check("rstmem.in_mem", {state_o, mem_req, mem_we, addr_sel}, {3'd3, 3'b111});
    rst = 1'b1; en = 1'b0;
    tick();
    check("rstmem.after", {state_o, mem_req, mem_we}, 0);
    rst = 1'b0;
    tick(); tick();
    check("rstmem.idle", {state_o, mem_req, ir_we}, 0);

    // Dropping en while a fetch is outstanding keeps the request up.
    en = 1'b1;
    #1;
    check("enhold.req0", mem_req, 1);
    tick();
    en = 1'b0;
    #1;
    check("enhold.req1", mem_req, 1);
    tick(); tick();
    check("enhold.req3", {state_o, mem_req}, {3'd0, 1'b1});
    mem_ready = 1'b1;
    #1;
    check("enhold.ir_we", ir_we, 1);
    tick();
    mem_ready = 1'b0;
    check("enhold.decode", state_o, 1);

    // Randomized legal stream against the reference model.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ri;
      logic rbe, rbl;
      int rfw, rmw;
      ri  = rand_legal();
      rbe = 1'($urandom_range(0, 1));
      rbl = 1'($urandom_range(0, 1));
      rfw = $urandom_range(0, 2);
      rmw = $urandom_range(0, 3);
      e = model(ri, rbe, rbl, rfw, rmw);
      run_instr(ri, rbe, rbl, rfw, rmw, o);
      exp_instret++;
      check($sformatf("r%0d.cycles i=%08h", k, ri), o.cycles, e.cycles);
      check($sformatf("r%0d.alu_in i=%08h", k, ri), {o.asel, o.bsel, o.imm, o.alu, o.brun},
            {e.asel, e.bsel, e.imm, e.alu, e.brun});
      check($sformatf("r%0d.pcsel i=%08h", k, ri), o.pcsel, e.pcsel);
      check($sformatf("r%0d.wb i=%08h", k, ri), {o.regwen, o.wbsel, o.memwe}, {e.regwen, e.wbsel, e.memwe});
      check($sformatf("r%0d.memc i=%08h", k, ri), o.memc, e.memc);
      check($sformatf("r%0d.instret", k), instret, exp_instret);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
